cv32e40s_alert_agg: RTL
=======================

// Module: cv32e40s_alert_agg
// PURPOSE
//  Parametrised alert aggregator: combines NUM_SRC alert sources, each classed minor or major by MAJOR_MASK.
//  Registers minor/major alert pulses and holds sticky per-source cause bits until a clear handshake.
//  Escalates repeated minor alerts inside a time window to a major alert.
//  Sits beside the controller; its outputs drive the core alert_minor_o/alert_major_o pins.
// PARAMETERS
//  NUM_SRC        5        number of alert sources (1..32)
//  MAJOR_MASK     'b11110  bit i=1: source i is major, 0: minor
//  ESC_THRESHOLD  4        minor-alert cycles within one window that trigger escalation (>=2)
//  ESC_WINDOW     1024     window length in cycles (>=1)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        reset, synchronous, active-low
//  alert_src_i    in   NUM_SRC  per-source alert condition, level, sampled every cycle
//  clr_req_i      in   1        request to clear cause bits and escalation state
//  clr_ack_o      out  1        clear performed (1-cycle pulse)
//  alert_minor_o  out  1        registered minor alert
//  alert_major_o  out  1        registered major alert (incl. escalation)
//  alert_esc_o    out  1        level: escalation state active
//  alert_cause_o  out  NUM_SRC  sticky cause bits
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): all outputs 0, FSM=IDLE, counters 0.
//  Latency 1: src sampled at edge t -> outputs valid after edge t+1. No combinational in->out paths.
//  minor_evt = |(alert_src_i & ~MAJOR_MASK); major_evt = |(alert_src_i & MAJOR_MASK).
//  alert_minor_o <= minor_evt; alert_major_o <= major_evt | esc_fire (esc_fire: FSM enters ESC this cycle).
//  Cause: cause <= (clr ? 0 : cause) | alert_src_i; set dominates clear in the same cycle.
//  Clear handshake: clr_req_i high -> clear executes that edge, clr_ack_o=1 the next cycle only.
//   clr_req_i held high: clears/acks every cycle.
//  Escalation FSM (alert_esc_state_e): IDLE, COUNT, ESC.
//   IDLE : minor_evt -> COUNT, evt_cnt=1, win_cnt=ESC_WINDOW-1.
//   COUNT: win_cnt decrements each cycle; minor_evt increments evt_cnt.
//          evt_cnt+1==ESC_THRESHOLD on minor_evt -> ESC (esc_fire, major pulse).
//          win_cnt==0 without escalation -> IDLE; if minor_evt that cycle, restart COUNT with evt_cnt=1.
//   ESC  : alert_esc_o=1; counters frozen; leave only on clear -> IDLE, or COUNT (evt_cnt=1) if minor_evt.
//  Counter widths: win_cnt $clog2(ESC_WINDOW+1), evt_cnt $clog2(ESC_THRESHOLD+1); never wrap.
//  Major sources never change FSM state. clr_req_i in IDLE/COUNT resets counters to IDLE too.
//  Parameter legality checked by elaboration-time assertions.
// CONFIGURATION
//  CV32E40S_ALERT_ESC_EN defined: escalation FSM/counters present, as above.
//  Not defined: no FSM/counters; alert_esc_o tied 0; alert_major_o <= major_evt only.
// STRUCTURE
//  cv32e40s_pkg: alert_esc_state_e, alert source index constants (ALERT_IDX_*), default MAJOR_MASK.
//  Sub-module cv32e40s_alert_esc_cnt: window + event counters and FSM; instantiated under the macro.
// TESTING
//  src[0] (minor) 1 cycle -> alert_minor_o=1 exactly 1 cycle later, cause=5'b00001, major=0.
//  src[2] (major) + src[0] same cycle -> minor=major=1 next cycle; cause=5'b00101.
//  4 minor pulses in 10 cycles, window 1024 -> 4th sample: alert_major_o pulse + alert_esc_o=1 held.
//  3 minors, then 1024 idle cycles, then 1 minor -> FSM back to COUNT evt_cnt=1, no escalation.
//  clr_req_i with src[1] high same cycle -> cause=5'b00010, clr_ack_o next cycle; ESC->IDLE.
//  rst_n low mid-COUNT (evt_cnt=3) -> next edge all outputs 0, FSM IDLE; macro off: alert_esc_o stays 0.

Source files
------------

// File: rtl/cv32e40s_pkg.sv
// cv32e40s_pkg: alert aggregator types, source indices and default major-source mask.
package cv32e40s_pkg;
  typedef enum logic [1:0] {
    ALERT_ESC_IDLE,
    ALERT_ESC_COUNT,
    ALERT_ESC_ESC
  } alert_esc_state_e;
  localparam int ALERT_IDX_SOFT     = 0;
  localparam int ALERT_IDX_PARITY   = 1;
  localparam int ALERT_IDX_ECC      = 2;
  localparam int ALERT_IDX_LOCKSTEP = 3;
  localparam int ALERT_IDX_PC_CHECK = 4;
  localparam logic [31:0] ALERT_MAJOR_MASK_DEFAULT = 32'h0000_001E;
endpackage

// File: rtl/cv32e40s_alert_esc_cnt.sv
// cv32e40s_alert_esc_cnt: window/event counters and FSM escalating repeated minor alerts.
module cv32e40s_alert_esc_cnt
  import cv32e40s_pkg::*;
#(
  parameter int ESC_THRESHOLD = 4,
  parameter int ESC_WINDOW    = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic minor_evt,
  input  logic clr,
  output logic esc_fire,
  output logic esc_active
);
  localparam int WW = $clog2(ESC_WINDOW + 1);
  localparam int EW = $clog2(ESC_THRESHOLD + 1);
  localparam logic [WW-1:0] WIN_INIT = WW'(ESC_WINDOW - 1);
  localparam logic [EW-1:0] EVT_LAST = EW'(ESC_THRESHOLD - 1);
  localparam logic [EW-1:0] EVT_ONE  = EW'(1);
  if (ESC_THRESHOLD < 2) begin : g_bad_thr
    $error("ESC_THRESHOLD must be >= 2");
  end
  if (ESC_WINDOW < 1) begin : g_bad_win
    $error("ESC_WINDOW must be >= 1");
  end
  alert_esc_state_e state_q, state_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] evt_q, evt_d;
  logic restart;
  assign restart = clr || state_q == ALERT_ESC_IDLE || (state_q == ALERT_ESC_COUNT && win_q == '0);
  // Escalation beats window expiry; clear beats escalation, then a same-cycle minor reopens a window.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    evt_d    = evt_q;
    esc_fire = 1'b0;
    if (state_q == ALERT_ESC_COUNT && !clr && minor_evt && evt_q == EVT_LAST) begin
      state_d  = ALERT_ESC_ESC;
      esc_fire = 1'b1;
    end else if (restart) begin
      state_d = minor_evt ? ALERT_ESC_COUNT : ALERT_ESC_IDLE;
      win_d   = minor_evt ? WIN_INIT : '0;
      evt_d   = minor_evt ? EVT_ONE : '0;
    end else if (state_q == ALERT_ESC_COUNT) begin
      win_d = win_q - 1'b1;
      evt_d = evt_q + EW'(minor_evt);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ALERT_ESC_IDLE;
      win_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      evt_q   <= evt_d;
    end
  end
  assign esc_active = state_q == ALERT_ESC_ESC;
endmodule

// File: rtl/cv32e40s_alert_agg.sv
// cv32e40s_alert_agg: registered minor/major alert aggregation with sticky causes and clear handshake.
// Escalation of repeated minor alerts is built only when CV32E40S_ALERT_ESC_EN is defined.
module cv32e40s_alert_agg
  import cv32e40s_pkg::*;
#(
  parameter int          NUM_SRC       = 5,
  parameter logic [31:0] MAJOR_MASK    = ALERT_MAJOR_MASK_DEFAULT,
  parameter int          ESC_THRESHOLD = 4,
  parameter int          ESC_WINDOW    = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] alert_src_i,
  input  logic               clr_req_i,
  output logic               clr_ack_o,
  output logic               alert_minor_o,
  output logic               alert_major_o,
  output logic               alert_esc_o,
  output logic [NUM_SRC-1:0] alert_cause_o
);
  if (NUM_SRC < 1 || NUM_SRC > 32) begin : g_bad_num_src
    $error("NUM_SRC must be 1..32");
  end
  if (ESC_THRESHOLD < 2) begin : g_bad_thr
    $error("ESC_THRESHOLD must be >= 2");
  end
  if (ESC_WINDOW < 1) begin : g_bad_win
    $error("ESC_WINDOW must be >= 1");
  end
  localparam logic [NUM_SRC-1:0] MASK = MAJOR_MASK[NUM_SRC-1:0];
  logic minor_evt, major_evt, esc_fire;
  assign minor_evt = |(alert_src_i & ~MASK);
  assign major_evt = |(alert_src_i & MASK);
`ifdef CV32E40S_ALERT_ESC_EN
  cv32e40s_alert_esc_cnt #(
    .ESC_THRESHOLD(ESC_THRESHOLD),
    .ESC_WINDOW   (ESC_WINDOW)
  ) u_esc_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .minor_evt (minor_evt),
    .clr       (clr_req_i),
    .esc_fire  (esc_fire),
    .esc_active(alert_esc_o)
  );
`else
  assign esc_fire    = 1'b0;
  assign alert_esc_o = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alert_minor_o <= 1'b0;
      alert_major_o <= 1'b0;
      alert_cause_o <= '0;
      clr_ack_o     <= 1'b0;
    end else begin
      alert_minor_o <= minor_evt;
      alert_major_o <= major_evt | esc_fire;
      alert_cause_o <= (clr_req_i ? '0 : alert_cause_o) | alert_src_i;
      clr_ack_o     <= clr_req_i;
    end
  end
endmodule
